temp_sample_sequencer: RTL and testbench
========================================

// Module: temp_sample_sequencer
// PURPOSE
//  Sequences the temperature logger datapath. A periodic tick triggers one SPI sensor read;
//  the block waits for completion with a timeout, then hands the reading to the UART
//  formatter over a valid/ready handshake. Sits in temp_logger_top between the SPI master
//  and the UART formatter/TX, and drives status_leds.
// PARAMETERS
//  PERIOD_CYC      10_000_000  clk cycles between sample ticks (1 s at 10 MHz); >= 2
//  SPI_TIMEOUT_CYC 4096        max cycles in WAIT_SPI before abort
//  DATA_W          16          sensor reading width
// PORTS
//  clk          in   1       system clock, 10 MHz
//  rst          in   1       synchronous, active-high reset
//  enable       in   1       run sampling when 1
//  spi_start    out  1       one-cycle pulse: start sensor read
//  spi_busy     in   1       SPI master busy
//  spi_done     in   1       one-cycle pulse: spi_rdata valid
//  spi_rdata    in   DATA_W  sensor reading
//  tx_valid     out  1       tx_data/tx_seq valid
//  tx_ready     in   1       formatter accepts (transfer = tx_valid & tx_ready)
//  tx_data      out  DATA_W  reading to log
//  tx_seq       out  8       sample sequence number
//  status_leds  out  2       [0] heartbeat, [1] sticky error
//  err_count    out  8       saturating error counter
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; tick counter 0; tx_seq 0; error flag cleared.
//  Tick counter: counts 0..PERIOD_CYC-1 while enable=1, tick on wrap; held at 0 when enable=0.
//  FSM:
//   IDLE      -> WAIT_TICK when enable=1.
//   WAIT_TICK -> START on tick; -> IDLE if enable=0.
//   START     pulse spi_start for 1 cycle once spi_busy=0 (wait while busy) -> WAIT_SPI.
//             Tick-to-spi_start latency: 1 cycle when SPI idle.
//   WAIT_SPI  on spi_done latch spi_rdata -> PUSH. On timeout count = SPI_TIMEOUT_CYC
//             -> error, -> WAIT_TICK, no tx. spi_done and timeout in the same cycle: done wins.
//   PUSH      tx_valid=1 from the cycle after spi_done; tx_data/tx_seq stable until transfer.
//             On transfer: tx_seq++ (wraps 255->0), status_leds[0] toggles,
//             -> WAIT_TICK (IDLE if enable=0).
//  Overrun: a tick while in START/WAIT_SPI/PUSH is an error; that sample is dropped
//   (not queued). The current operation continues.
//  Error: err_count += 1, saturating at 255; status_leds[1] := 1, cleared only by rst.
//  enable=0 mid-sample: the current read and push complete, then -> IDLE; no new spi_start.
//  rst mid-operation: immediate return to reset state; a pending tx is discarded.
// CONFIGURATION
//  SAMPLE_AVG_EN defined: successful reads feed an (DATA_W+2)-bit accumulator. Every 4th
//   read enters PUSH with tx_data = acc>>2 (truncated), then the accumulator clears.
//   Reads 1-3 return to WAIT_TICK without tx. A timeout also clears the accumulator and
//   its read count. tx_seq counts averaged outputs.
//  SAMPLE_AVG_EN undefined: every successful read is pushed raw; no accumulator.
// STRUCTURE
//  temp_logger_pkg holds: FSM state encoding localparams (IDLE, WAIT_TICK, START,
//   WAIT_SPI, PUSH), SEQ_W=8, ERR_W=8, default CLK_HZ.
//  Sub-module period_tick_gen (PERIOD_CYC; clk, rst, enable -> tick) carries the tick counter.
// TESTING
//  1 PERIOD_CYC=100; SPI model returns 16'h0C80 20 cycles after start -> spi_start 1 cycle
//    after tick; tx_valid with tx_data=16'h0C80, tx_seq=0; status_leds=2'b01 after transfer.
//  2 tx_ready low 150 cycles -> tx_data stable; tick during PUSH gives err_count=1,
//    status_leds[1]=1, no second spi_start until transfer.
//  3 SPI_TIMEOUT_CYC=50, spi_done never -> no tx_valid; err_count=1 at cycle 51 of WAIT_SPI;
//    next tick issues a new spi_start. spi_done coincident with timeout -> pushed, no error.
//  4 257 back-to-back samples -> tx_seq ...254,255,0; err_count holds 255 after 300 forced timeouts.
//  5 enable=0 during WAIT_SPI -> sample still pushed, then IDLE, no spi_start for 3 periods.
//    rst during PUSH -> tx_valid=0 next cycle, tx_seq=0, leds=0.
//  6 SAMPLE_AVG_EN: reads 100,101,102,103 -> single transfer tx_data=101, tx_seq=0;
//    a timeout after 2 reads discards them.

Source files
------------

// File: rtl/temp_logger_pkg.sv
// Shared types and constants for the temperature logger datapath.
// Combinational helpers only; no latency and no flow control.
package temp_logger_pkg;

  localparam int SEQ_W  = 8;
  localparam int ERR_W  = 8;
  localparam int CLK_HZ = 10_000_000;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t WAIT_TICK = 3'd1;
  localparam state_t START     = 3'd2;
  localparam state_t WAIT_SPI  = 3'd3;
  localparam state_t PUSH      = 3'd4;

  // Timeout and overrun can land in the same cycle, so up to two errors per cycle.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] v, input logic [1:0] n);
    logic [ERR_W:0] s;
    s = {1'b0, v} + {{(ERR_W-1){1'b0}}, n};
    return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/period_tick_gen.sv
// Sample period timer: one-cycle tick on the last count of each PERIOD_CYC window while enabled.
// Tick is combinational from the counter; counter is held at 0 while disabled; no backpressure.
module period_tick_gen #(
  parameter int PERIOD_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/temp_sample_sequencer.sv
// Tick -> SPI read (with timeout) -> tx valid/ready push; `SAMPLE_AVG_EN pushes the mean of every 4 reads.
// spi_start 1 cycle after tick, tx_valid 1 cycle after spi_done; tx held until tx_ready, ticks meanwhile are overruns.
module temp_sample_sequencer
  import temp_logger_pkg::*;
#(
  parameter int PERIOD_CYC      = 10_000_000,
  parameter int SPI_TIMEOUT_CYC = 4096,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              spi_start,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [SEQ_W-1:0]  tx_seq,
  output logic [1:0]        status_leds,
  output logic [ERR_W-1:0]  err_count
);

  localparam int TO_W = (SPI_TIMEOUT_CYC > 1) ? $clog2(SPI_TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(SPI_TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              tick;
  logic [TO_W-1:0]   wait_cnt;
  logic              spi_hit, timeout, overrun, xfer, push_now;
  logic [DATA_W-1:0] push_data;
  logic              heartbeat, err_flag;

  period_tick_gen #(
    .PERIOD_CYC (PERIOD_CYC)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign spi_hit = (state == WAIT_SPI) && spi_done;
  // A done on the final timeout cycle still counts as a good read.
  assign timeout = (state == WAIT_SPI) && !spi_done && (wait_cnt == TO_LAST);
  assign overrun = tick && (state inside {START, WAIT_SPI, PUSH});
  assign xfer    = (state == PUSH) && tx_ready;

`ifdef SAMPLE_AVG_EN
  logic [DATA_W+1:0] acc, acc_sum;
  logic [1:0]        rd_cnt;

  assign acc_sum   = acc + {2'b00, spi_rdata};
  assign push_now  = spi_hit && (rd_cnt == 2'd3);
  assign push_data = acc_sum[DATA_W+1:2];

  always_ff @(posedge clk) begin
    if (rst || timeout) begin
      acc    <= '0;
      rd_cnt <= '0;
    end else if (spi_hit) begin
      if (rd_cnt == 2'd3) begin
        acc    <= '0;
        rd_cnt <= '0;
      end else begin
        acc    <= acc_sum;
        rd_cnt <= rd_cnt + 2'd1;
      end
    end
  end
`else
  assign push_now  = spi_hit;
  assign push_data = spi_rdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)   state_nxt = IDLE;
        else if (tick) state_nxt = START;
      end
      START:     if (!spi_busy) state_nxt = WAIT_SPI;
      WAIT_SPI: begin
        if (push_now)                state_nxt = PUSH;
        else if (spi_hit || timeout) state_nxt = WAIT_TICK;
      end
      PUSH:      if (tx_ready) state_nxt = enable ? WAIT_TICK : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_start = (state == START) && !spi_busy;
    tx_valid  = (state == PUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      tx_data   <= '0;
      tx_seq    <= '0;
      heartbeat <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      wait_cnt <= (state == WAIT_SPI) ? wait_cnt + TO_W'(1) : '0;
      if (push_now) begin
        tx_data <= push_data;
      end
      if (xfer) begin
        tx_seq    <= tx_seq + SEQ_W'(1);
        heartbeat <= ~heartbeat;
      end
      if (timeout || overrun) begin
        err_flag  <= 1'b1;
        err_count <= sat_add(err_count, {1'b0, timeout} + {1'b0, overrun});
      end
    end
  end

  assign status_leds = {err_flag, heartbeat};

endmodule

// File: tb/tb_temp_sample_sequencer.sv
// Self-checking bench for temp_sample_sequencer with a latency-programmable SPI responder.
module tb_temp_sample_sequencer;

  localparam int P  = 100;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst, enable, tx_ready, ext_busy, model_busy;
  logic        spi_start, spi_busy, spi_done, tx_valid;
  logic [15:0] spi_rdata, tx_data;
  logic [7:0]  tx_seq, err_count;
  logic [1:0]  status_leds;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int en_cyc   = 0;

  // SPI responder config: spi_lat <= 0 means the read never completes.
  int          spi_lat = 20;
  logic [15:0] spi_val = 16'h0;
  int          m_lat;
  logic [15:0] m_val;

  assign spi_busy = model_busy | ext_busy;

  temp_sample_sequencer #(
    .PERIOD_CYC      (P),
    .SPI_TIMEOUT_CYC (TO),
    .DATA_W          (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .spi_start   (spi_start),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_seq      (tx_seq),
    .status_leds (status_leds),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Responder acts 2 time units after the edge; the bench samples/drives at 1.
  initial begin
    model_busy = 1'b0;
    spi_done   = 1'b0;
    spi_rdata  = '0;
    forever begin
      @(posedge clk); #2;
      if (spi_start === 1'b1) begin
        m_lat = spi_lat;
        m_val = spi_val;
        if (m_lat <= 0) begin
          for (int i = 0; i < 40; i++) begin @(posedge clk); #2; model_busy = 1'b1; end
          @(posedge clk); #2; model_busy = 1'b0;
        end else begin
          for (int i = 1; i < m_lat; i++) begin @(posedge clk); #2; model_busy = 1'b1; end
          @(posedge clk); #2; model_busy = 1'b0; spi_done = 1'b1; spi_rdata = m_val;
          @(posedge clk); #2; spi_done = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; tx_ready = 1'b0; ext_busy = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic go();
    enable = 1'b1;
    en_cyc = cyc;
  endtask

  // rel = cycle of spi_start counted from the enable cycle, -1 if never seen.
  task automatic wait_start(input int budget, output int rel);
    rel = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (spi_start === 1'b1) begin rel = cyc - en_cyc; return; end
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (tx_valid === 1'b1) begin n = i; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; tx_ready = 1'b1; ext_busy = 1'b0;
    repeat (4) step();
    n_checks++; if (spi_start !== 1'b0) $display("FAIL reset_spi_start: got %b want 0", spi_start); else n_pass++;
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else n_pass++;
    n_checks++; if (tx_data !== 16'h0) $display("FAIL reset_tx_data: got %h want 0", tx_data); else n_pass++;
    n_checks++; if (tx_seq !== 8'h0) $display("FAIL reset_tx_seq: got %0d want 0", tx_seq); else n_pass++;
    n_checks++; if (status_leds !== 2'b00) $display("FAIL reset_leds: got %b want 00", status_leds); else n_pass++;
    n_checks++; if (err_count !== 8'h0) $display("FAIL reset_err: got %0d want 0", err_count); else n_pass++;
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_single();
    int rel, n;
    do_reset(); tx_ready = 1'b1; spi_val = 16'h0C80; spi_lat = 20; go();
    wait_start(2*P, rel);
    n_checks++; if (rel != P) $display("FAIL single_start_cycle: got %0d want %0d", rel, P); else n_pass++;
    wait_valid(60, n);
    n_checks++; if (n != 21) $display("FAIL single_valid_latency: got %0d want 21", n); else n_pass++;
    n_checks++; if (tx_data !== 16'h0C80) $display("FAIL single_data: got %h want 0c80", tx_data); else n_pass++;
    n_checks++; if (tx_seq !== 8'd0) $display("FAIL single_seq: got %0d want 0", tx_seq); else n_pass++;
    step();
    n_checks++; if (status_leds !== 2'b01) $display("FAIL single_leds: got %b want 01", status_leds); else n_pass++;
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", tx_valid); else n_pass++;
  endtask

  task automatic test_busy_wait();
    int n, bad;
    logic [15:0] v;
    do_reset(); tx_ready = 1'b1; ext_busy = 1'b1;
    v = 16'($urandom); spi_val = v; spi_lat = $urandom_range(5, 30); go();
    bad = 0;
    for (int i = 0; i < P + 5; i++) begin step(); if (spi_start !== 1'b0) bad++; end
    n_checks++; if (bad != 0) $display("FAIL busy_start_held: got %0d starts want 0", bad); else n_pass++;
    ext_busy = 1'b0; #1;
    n_checks++; if (spi_start !== 1'b1) $display("FAIL busy_release_start: got %b want 1", spi_start); else n_pass++;
    step();
    n_checks++; if (spi_start !== 1'b0) $display("FAIL busy_start_pulse: got %b want 0", spi_start); else n_pass++;
    wait_valid(60, n);
    n_checks++; if (n != spi_lat) $display("FAIL busy_valid_latency: got %0d want %0d", n, spi_lat); else n_pass++;
    n_checks++; if (tx_data !== v) $display("FAIL busy_data: got %h want %h", tx_data, v); else n_pass++;
  endtask

  task automatic test_backpressure();
    int rel, n, bad, v_cyc, t, exp_err, exp_start;
    logic [15:0] held;
    do_reset(); tx_ready = 1'b0; spi_val = 16'($urandom); spi_lat = $urandom_range(5, 30); go();
    wait_start(2*P, rel);
    n_checks++; if (rel != P) $display("FAIL bp_start_cycle: got %0d want %0d", rel, P); else n_pass++;
    wait_valid(60, n);
    n_checks++; if (n != spi_lat + 1) $display("FAIL bp_valid_latency: got %0d want %0d", n, spi_lat + 1); else n_pass++;
    v_cyc = cyc - en_cyc;
    held = spi_val;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (tx_valid !== 1'b1 || tx_data !== held || tx_seq !== 8'd0 || spi_start !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else n_pass++;
    t = cyc - en_cyc;
    exp_err = 0;
    for (int m = 1; m*P - 1 <= t; m++) if (m*P - 1 >= v_cyc) exp_err++;
    n_checks++; if (err_count !== 8'(exp_err)) $display("FAIL bp_overrun_err: got %0d want %0d", err_count, exp_err); else n_pass++;
    n_checks++; if (status_leds !== 2'b10) $display("FAIL bp_leds_err: got %b want 10", status_leds); else n_pass++;
    tx_ready = 1'b1;
    exp_start = P * ((t + 2 + P - 1) / P);
    wait_start(3*P, rel);
    n_checks++; if (rel != exp_start) $display("FAIL bp_next_start: got %0d want %0d", rel, exp_start); else n_pass++;
    n_checks++; if (status_leds !== 2'b11) $display("FAIL bp_leds_after: got %b want 11", status_leds); else n_pass++;
  endtask

  task automatic test_timeout();
    int rel, n, bad;
    logic [15:0] v;
    do_reset(); tx_ready = 1'b1; spi_lat = 0; go();
    wait_start(2*P, rel);
    n_checks++; if (rel != P) $display("FAIL to_start_cycle: got %0d want %0d", rel, P); else n_pass++;
    bad = 0;
    for (int i = 0; i < TO; i++) begin step(); if (tx_valid !== 1'b0) bad++; end
    n_checks++; if (err_count !== 8'd0) $display("FAIL to_err_early: got %0d want 0", err_count); else n_pass++;
    step();
    n_checks++; if (err_count !== 8'd1) $display("FAIL to_err_count: got %0d want 1", err_count); else n_pass++;
    n_checks++; if (status_leds !== 2'b10) $display("FAIL to_leds: got %b want 10", status_leds); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL to_no_tx: got %0d valid cycles want 0", bad); else n_pass++;
    v = 16'($urandom); spi_val = v; spi_lat = TO;
    wait_start(2*P, rel);
    n_checks++; if (rel != 2*P) $display("FAIL to_restart: got %0d want %0d", rel, 2*P); else n_pass++;
    wait_valid(TO + 10, n);
    n_checks++; if (n != TO + 1) $display("FAIL to_coincident_push: got %0d want %0d", n, TO + 1); else n_pass++;
    n_checks++; if (tx_data !== v) $display("FAIL to_coincident_data: got %h want %h", tx_data, v); else n_pass++;
    n_checks++; if (err_count !== 8'd1) $display("FAIL to_coincident_err: got %0d want 1", err_count); else n_pass++;
    spi_lat = TO + 1;
    wait_start(2*P, rel);
    n_checks++; if (rel != 3*P) $display("FAIL to_late_start: got %0d want %0d", rel, 3*P); else n_pass++;
    bad = 0;
    for (int i = 0; i < TO + 1; i++) begin step(); if (tx_valid !== 1'b0) bad++; end
    n_checks++; if (err_count !== 8'd2) $display("FAIL to_late_err: got %0d want 2", err_count); else n_pass++;
    for (int i = 0; i < 5; i++) begin step(); if (tx_valid !== 1'b0) bad++; end
    n_checks++; if (bad != 0) $display("FAIL to_late_no_tx: got %0d valid cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_err_saturate();
    int rel, exp;
    do_reset(); tx_ready = 1'b1; spi_lat = 0; go();
    for (int i = 1; i <= 300; i++) begin
      wait_start(2*P, rel);
      n_checks++; if (rel != i*P) $display("FAIL sat_start_%0d: got %0d want %0d", i, rel, i*P); else n_pass++;
      repeat (TO + 1) step();
      exp = (i > 255) ? 255 : i;
      n_checks++; if (err_count !== 8'(exp)) $display("FAIL sat_err_%0d: got %0d want %0d", i, err_count, exp); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int rel, n;
    logic [15:0] v;
    do_reset(); tx_ready = 1'b1; go();
    for (int i = 0; i < 257; i++) begin
      v = 16'($urandom); spi_val = v; spi_lat = $urandom_range(3, 40);
      wait_start(2*P, rel);
      n_checks++; if (rel != (i + 1)*P) $display("FAIL b2b_start_%0d: got %0d want %0d", i, rel, (i + 1)*P); else n_pass++;
      wait_valid(60, n);
      n_checks++; if (tx_data !== v) $display("FAIL b2b_data_%0d: got %h want %h", i, tx_data, v); else n_pass++;
      n_checks++; if (tx_seq !== 8'(i)) $display("FAIL b2b_seq_%0d: got %0d want %0d", i, tx_seq, i % 256); else n_pass++;
    end
    step();
    n_checks++; if (status_leds !== 2'b01) $display("FAIL b2b_leds: got %b want 01", status_leds); else n_pass++;
    tx_ready = 1'b0; spi_val = 16'($urandom); spi_lat = $urandom_range(3, 40);
    wait_start(2*P, rel);
    wait_valid(60, n);
    n_checks++; if (tx_seq !== 8'd1) $display("FAIL b2b_seq_wrap: got %0d want 1", tx_seq); else n_pass++;
    repeat (3) step();
    rst = 1'b1;
    step();
    n_checks++; if (tx_valid !== 1'b0) $display("FAIL rst_push_valid: got %b want 0", tx_valid); else n_pass++;
    n_checks++; if (tx_seq !== 8'd0) $display("FAIL rst_push_seq: got %0d want 0", tx_seq); else n_pass++;
    n_checks++; if (status_leds !== 2'b00) $display("FAIL rst_push_leds: got %b want 00", status_leds); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_disable();
    int rel, n, bad;
    logic [15:0] v;
    do_reset(); tx_ready = 1'b1; v = 16'($urandom); spi_val = v; spi_lat = 30; go();
    wait_start(2*P, rel);
    n_checks++; if (rel != P) $display("FAIL dis_start_cycle: got %0d want %0d", rel, P); else n_pass++;
    repeat (10) step();
    enable = 1'b0;
    wait_valid(60, n);
    n_checks++; if (n != 21) $display("FAIL dis_push_latency: got %0d want 21", n); else n_pass++;
    n_checks++; if (tx_data !== v) $display("FAIL dis_push_data: got %h want %h", tx_data, v); else n_pass++;
    bad = 0;
    for (int i = 0; i < 3*P; i++) begin step(); if (spi_start !== 1'b0 || tx_valid !== 1'b0) bad++; end
    n_checks++; if (bad != 0) $display("FAIL dis_quiet: got %0d active cycles want 0", bad); else n_pass++;
    n_checks++; if (err_count !== 8'd0) $display("FAIL dis_err: got %0d want 0", err_count); else n_pass++;
    spi_val = 16'($urandom); go();
    wait_start(2*P, rel);
    n_checks++; if (rel != P) $display("FAIL dis_restart: got %0d want %0d", rel, P); else n_pass++;
    wait_valid(60, n);
    n_checks++; if (tx_seq !== 8'd1) $display("FAIL dis_restart_seq: got %0d want 1", tx_seq); else n_pass++;
  endtask

`ifdef SAMPLE_AVG_EN
  task automatic test_avg();
    int rel, n, bad, sum;
    logic [15:0] vals [7];
    do_reset(); tx_ready = 1'b1; spi_lat = 10; go();
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      spi_val = 16'(100 + k);
      wait_start(2*P, rel);
      n_checks++; if (rel != (k + 1)*P) $display("FAIL avg_start_%0d: got %0d want %0d", k, rel, (k + 1)*P); else n_pass++;
      if (k < 3) begin
        for (int i = 0; i < 20; i++) begin step(); if (tx_valid !== 1'b0) bad++; end
      end
    end
    wait_valid(60, n);
    n_checks++; if (bad != 0) $display("FAIL avg_early_tx: got %0d valid cycles want 0", bad); else n_pass++;
    n_checks++; if (tx_data !== 16'd101) $display("FAIL avg_data: got %0d want 101", tx_data); else n_pass++;
    n_checks++; if (tx_seq !== 8'd0) $display("FAIL avg_seq: got %0d want 0", tx_seq); else n_pass++;
    bad = 0;
    for (int j = 0; j < 7; j++) begin
      vals[j] = 16'($urandom);
      spi_val = vals[j];
      spi_lat = (j == 2) ? 0 : 10;
      wait_start(2*P, rel);
      if (j < 6) begin
        for (int i = 0; i < 60; i++) begin step(); if (tx_valid !== 1'b0) bad++; end
      end
    end
    wait_valid(60, n);
    sum = (int'(vals[3]) + int'(vals[4]) + int'(vals[5]) + int'(vals[6])) >> 2;
    n_checks++; if (bad != 0) $display("FAIL avg_discard_tx: got %0d valid cycles want 0", bad); else n_pass++;
    n_checks++; if (tx_data !== 16'(sum)) $display("FAIL avg_after_timeout: got %h want %h", tx_data, 16'(sum)); else n_pass++;
    n_checks++; if (tx_seq !== 8'd1) $display("FAIL avg_seq2: got %0d want 1", tx_seq); else n_pass++;
    n_checks++; if (err_count !== 8'd1) $display("FAIL avg_err: got %0d want 1", err_count); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; tx_ready = 1'b0; ext_busy = 1'b0;
    test_reset();
`ifdef SAMPLE_AVG_EN
    test_avg();
`else
    test_single();
    test_busy_wait();
    test_backpressure();
    test_timeout();
    test_disable();
    test_back_to_back();
    test_err_saturate();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
